// File: rtl/life_scheduler_pkg.sv
// Shared constants and FSM state encoding for the life generation scheduler.
package life_scheduler_pkg;
  localparam int LOG_MAX_SPEED = 4;
  localparam int BOARD_SIZE    = 64;

  typedef enum logic [1:0] {IDLE, START, RUN, SWAP} sched_state_e;
endpackage

// File: rtl/frame_timer.sv
// Counts vsync frames while enabled; pulses expire on the frame that completes a period.
module frame_timer
  import life_scheduler_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     vsync_in,
  input  logic [LOG_MAX_SPEED-1:0] speed_in,
  input  logic                     en,
  input  logic                     clr,
  output logic                     expire
);
  localparam logic [LOG_MAX_SPEED:0] FULL = {1'b1, {LOG_MAX_SPEED{1'b0}}};

  logic [LOG_MAX_SPEED-1:0] frame_cnt;
  logic [LOG_MAX_SPEED:0]   period;
  logic [LOG_MAX_SPEED:0]   cnt_inc;

  // One extra bit so period 2^LOG_MAX_SPEED - speed never overflows the compare.
  assign period  = FULL - {1'b0, speed_in};
  assign cnt_inc = {1'b0, frame_cnt} + (LOG_MAX_SPEED+1)'(1);
  assign expire  = en && vsync_in && (speed_in != '0) && (cnt_inc >= period);

  always_ff @(posedge clk_in) begin
    if (rst_in || speed_in == '0 || clr || expire)
      frame_cnt <= '0;
    else if (en && vsync_in)
      frame_cnt <= cnt_inc[LOG_MAX_SPEED-1:0];
  end
endmodule

// File: rtl/life_scheduler.sv
// Sequences life datapath passes: frame-timed or stepped rule passes, cursor edits, vsync-aligned buffer swaps.
module life_scheduler
  import life_scheduler_pkg::*;
#(
  parameter int GEN_COUNT_WIDTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       vsync_in,
  input  logic [LOG_MAX_SPEED-1:0]   speed_in,
  input  logic                       step_in,
  input  logic                       click_in,
  input  logic                       logic_done_in,
  output logic                       logic_start_out,
  output logic                       logic_update_out,
  output logic                       logic_click_out,
  output logic                       buf_sel_out,
  output logic [GEN_COUNT_WIDTH-1:0] gen_count_out,
  output logic                       busy_out
);
  sched_state_e state, state_nxt;
  logic click_pending, update_r, click_r, buf_sel;
  logic [GEN_COUNT_WIDTH-1:0] gen_count;
  logic expire, rule_trig, idle_go, swap_done;

  frame_timer u_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .vsync_in (vsync_in),
    .speed_in (speed_in),
    .en       (state == IDLE),
    .clr      (swap_done),
    .expire   (expire)
  );

  assign rule_trig = expire || (state == IDLE && speed_in == '0 && step_in);
  assign idle_go   = (state == IDLE) && (rule_trig || click_pending);
  assign swap_done = (state == SWAP) && vsync_in;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (idle_go) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (logic_done_in) state_nxt = SWAP;
      SWAP:    if (vsync_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      click_pending <= 1'b0;
      update_r      <= 1'b0;
      click_r       <= 1'b0;
      buf_sel       <= 1'b0;
      gen_count     <= '0;
    end else begin
      // A click landing in the same cycle its predecessor is consumed stays pending.
      click_pending <= click_in || (click_pending && !idle_go);
      if (idle_go) begin
        update_r <= rule_trig;
        click_r  <= click_pending;
      end
      if (swap_done) begin
        buf_sel  <= ~buf_sel;
        update_r <= 1'b0;
        click_r  <= 1'b0;
        if (update_r) gen_count <= gen_count + 1'b1;
      end
    end
  end

  // Masked by reset so an aborted START never leaks a start pulse.
  assign logic_start_out  = (state == START) && !rst_in;
  assign logic_update_out = update_r;
  assign logic_click_out  = click_r;
  assign buf_sel_out      = buf_sel;
  assign gen_count_out    = gen_count;
  assign busy_out         = (state != IDLE);
endmodule

// File: tb/tb_life_scheduler.sv
// Directed scoreboard bench for life_scheduler with a latency-programmable datapath responder.
module tb_life_scheduler;
  import life_scheduler_pkg::*;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in = 1'b1, vsync_in = 1'b0, step_in = 1'b0, click_in = 1'b0;
  logic [LOG_MAX_SPEED-1:0] speed_in = '0;
  logic logic_done_in, logic_start_out, logic_update_out, logic_click_out, buf_sel_out, busy_out;
  logic [15:0] gen_count_out;

  logic resp_done = 1'b0, man_done = 1'b0;
  assign logic_done_in = resp_done | man_done;

  life_scheduler #(.GEN_COUNT_WIDTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .vsync_in(vsync_in), .speed_in(speed_in),
    .step_in(step_in), .click_in(click_in), .logic_done_in(logic_done_in),
    .logic_start_out(logic_start_out), .logic_update_out(logic_update_out),
    .logic_click_out(logic_click_out), .buf_sel_out(buf_sel_out),
    .gen_count_out(gen_count_out), .busy_out(busy_out)
  );

  typedef struct packed {logic upd; logic clk; logic bsel; logic [15:0] gen;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0, n_start = 0;
  int lat = 20, rcnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Datapath model: done pulse lat cycles after each start.
  always @(posedge clk_in) begin
    resp_done <= 1'b0;
    if (rst_in) rcnt <= 0;
    else if (logic_start_out) rcnt <= lat;
    else if (rcnt > 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) resp_done <= 1'b1;
    end
  end

  // Monitor: every start is matched against the next expected pass.
  always @(negedge clk_in) begin
    if (!rst_in && !busy_out) check("click_idle", logic_click_out, 0);
    if (logic_start_out) begin
      n_start++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_start: got start with empty queue, want none");
      end else begin
        mon_e = exp_q.pop_front();
        check("start_update", logic_update_out, mon_e.upd);
        check("start_click",  logic_click_out,  mon_e.clk);
        check("start_bufsel", buf_sel_out,      mon_e.bsel);
        check("start_gen",    gen_count_out,    mon_e.gen);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic pulse_vsync; vsync_in = 1'b1; cyc(1); vsync_in = 1'b0; endtask
  task automatic pulse_step;  step_in  = 1'b1; cyc(1); step_in  = 1'b0; endtask
  task automatic pulse_click; click_in = 1'b1; cyc(1); click_in = 1'b0; endtask
  task automatic push(logic u, logic c, logic b, logic [15:0] g);
    exp_q.push_back('{upd: u, clk: c, bsel: b, gen: g});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    cyc(3);
    check("rst_busy", busy_out, 0);
    check("rst_buf",  buf_sel_out, 0);
    check("rst_gen",  gen_count_out, 0);
    check("rst_start", logic_start_out, 0);
    check("rst_update", logic_update_out, 0);
    rst_in = 1'b0;
    cyc(2);

    // Fastest speed, slow datapath: one pass per two vsyncs.
    lat = 100; speed_in = 4'd15;
    push(1, 0, 0, 16'd0);
    pulse_vsync;
    check("t1_busy_after_vsync", busy_out, 1);
    cyc(110);
    check("t1_swap_wait", busy_out, 1);
    check("t1_buf_before_vsync", buf_sel_out, 0);
    pulse_vsync;
    check("t1_buf1", buf_sel_out, 1);
    check("t1_gen1", gen_count_out, 1);
    cyc(3);
    check("t1_no_retrigger", busy_out, 0);
    push(1, 0, 1, 16'd1);
    pulse_vsync;
    cyc(110);
    pulse_vsync;
    check("t1_buf2", buf_sel_out, 0);
    check("t1_gen2", gen_count_out, 2);

    // Period 3.
    lat = 20; speed_in = 4'd13;
    cyc(2); pulse_vsync; cyc(3); pulse_vsync; cyc(3);
    check("t2_hold_a", busy_out, 0);
    push(1, 0, 0, 16'd2);
    pulse_vsync;
    check("t2_fire_a", busy_out, 1);
    cyc(30); pulse_vsync;
    check("t2_gen3", gen_count_out, 3);
    cyc(3); pulse_vsync; cyc(3); pulse_vsync; cyc(3);
    check("t2_hold_b", busy_out, 0);
    push(1, 0, 1, 16'd3);
    pulse_vsync;
    cyc(30); pulse_vsync;
    check("t2_buf", buf_sel_out, 0);
    check("t2_gen4", gen_count_out, 4);

    // Paused: vsync ignored, single step, second step during RUN ignored.
    speed_in = 4'd0;
    cyc(2); pulse_vsync; cyc(3);
    check("t3_paused_vsync", busy_out, 0);
    push(1, 0, 0, 16'd4);
    pulse_step;
    cyc(5); pulse_step;
    cyc(30); pulse_vsync;
    check("t3_buf", buf_sel_out, 1);
    check("t3_gen5", gen_count_out, 5);
    cyc(10);
    check("t3_step_ignored", busy_out, 0);

    // Click pass, plus a click during RUN that queues a second pass.
    push(0, 1, 1, 16'd5);
    pulse_click;
    cyc(5); pulse_click;
    cyc(30);
    push(0, 1, 0, 16'd5);
    pulse_vsync;
    check("t4_buf_a", buf_sel_out, 0);
    check("t4_gen_a", gen_count_out, 5);
    cyc(30); pulse_vsync;
    check("t4_buf_b", buf_sel_out, 1);
    check("t4_gen_b", gen_count_out, 5);
    cyc(5);
    check("t4_idle", busy_out, 0);

    // Pending click coincides with timer expiry: one combined pass.
    speed_in = 4'd15;
    cyc(2);
    push(1, 1, 1, 16'd5);
    click_in = 1'b1; cyc(1); click_in = 1'b0;
    vsync_in = 1'b1; cyc(1); vsync_in = 1'b0;
    cyc(30); pulse_vsync;
    check("t5_buf", buf_sel_out, 0);
    check("t5_gen6", gen_count_out, 6);
    cyc(10);
    check("t5_no_followup", busy_out, 0);

    // Reset mid-pass; a late done must not swap.
    speed_in = 4'd0; lat = 50;
    push(1, 0, 0, 16'd6);
    pulse_step;
    cyc(5);
    rst_in = 1'b1;
    check("t6_start_in_rst", logic_start_out, 0);
    cyc(1);
    rst_in = 1'b0;
    check("t6_busy", busy_out, 0);
    check("t6_buf", buf_sel_out, 0);
    check("t6_gen", gen_count_out, 0);
    check("t6_update", logic_update_out, 0);
    cyc(1);
    check("t6_start_after", logic_start_out, 0);
    man_done = 1'b1; cyc(1); man_done = 1'b0;
    pulse_vsync;
    check("t6_late_done_buf", buf_sel_out, 0);
    check("t6_late_done_busy", busy_out, 0);

    cyc(5);
    check("queue_drained", exp_q.size(), 0);
    check("start_count", n_start, 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
